cam_bank_packer: RTL and testbench

- Parametrised camera capture engine in the PCLKI domain.
- Packs 8-bit camera bytes into words and writes them round-robin into NUM_BANKS external 2-port RAM banks.
- Tracks per-bank full flags with a software release handshake, detects overflow, counts frames and lines, and offers test-pattern modes.
- Sits between the camera pins and the banked frame RAMs; status feeds the Wishbone register block.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_tgl_sync.sv | 34 +++
 rtl/cam_bank_packer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cam_bank_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera bank packer.
//   - cam_state_e : capture FSM state encoding
//   - MODE_*      : data-source selection codes for mode_i
//   - DEF_*       : default geometry (bytes per word, bank count, bank address width)
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    STALL      = 2'd3
  } cam_state_e;

  localparam logic [1:0] MODE_CAM     = 2'd0;
  localparam logic [1:0] MODE_FREERUN = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam int DEF_BPW       = 4;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_BANK_AW   = 9;
  localparam int DEF_BANK_IW   = 2;

endpackage

// File: rtl/cam_tgl_sync.sv
// cam_tgl_sync: single-bit toggle synchroniser with edge-detect pulse.
// The source domain flips tgl on every event; this block re-times it
// through two flops and emits a one-cycle pulse per observed flip.
//   PCLKI      in  destination clock
//   WBs_RST_i  in  asynchronous active-high reset
//   tgl        in  toggle from the foreign clock domain
//   pulse      out one-cycle pulse per toggle
module cam_tgl_sync (
  input  logic PCLKI,
  input  logic WBs_RST_i,
  input  logic tgl,
  output logic pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= tgl;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  // Either direction of the toggle counts as one event.
  assign pulse = sync_reg ^ prev_reg;

endmodule

// File: rtl/cam_bank_packer.sv
// cam_bank_packer: packs 8-bit camera bytes into BPW-byte words and writes
// them round-robin into NUM_BANKS external RAM banks.
//   PCLKI / WBs_RST_i   clock / asynchronous active-high reset
//   VSYNCI, HREFI       frame and line valid from the sensor
//   CAM_D_i             camera byte
//   enable_i, mode_i    capture enable and data source (cam/freerun/ramp)
//   bank_rel_tgl_i      per-bank release toggles from the bus clock domain
//   ram_wa_o/wd_o/wen_o RAM write port (wen one-hot per bank, one cycle)
//   bank_full_o         banks holding a completed fill awaiting release
//   cur_bank_o          bank being filled
//   overflow_o          sticky drop indicator
//   frame_cnt_o         completed frames
//   line_cnt_o          lines seen in the current frame
module cam_bank_packer
  import cam_pkg::*;
#(
  parameter int BPW       = DEF_BPW,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_AW   = DEF_BANK_AW,
  parameter int BANK_IW   = DEF_BANK_IW
) (
  input  logic                 PCLKI,
  input  logic                 WBs_RST_i,
  input  logic                 VSYNCI,
  input  logic                 HREFI,
  input  logic [7:0]           CAM_D_i,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [NUM_BANKS-1:0] bank_rel_tgl_i,
  output logic [BANK_AW-1:0]   ram_wa_o,
  output logic [8*BPW-1:0]     ram_wd_o,
  output logic [NUM_BANKS-1:0] ram_wen_o,
  output logic [NUM_BANKS-1:0] bank_full_o,
  output logic [BANK_IW-1:0]   cur_bank_o,
  output logic                 overflow_o,
  output logic [15:0]          frame_cnt_o,
  output logic [15:0]          line_cnt_o
);

  localparam int DW  = 8 * BPW;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  cam_state_e state_reg, state_next;

  logic                 vsync_reg, href_reg, enable_reg;
  logic [BCW-1:0]       byte_cnt_reg, byte_cnt_next;
  logic [DW-1:0]        pack_reg, pack_next;
  logic [BANK_AW-1:0]   addr_reg, addr_next;
  logic [BANK_IW-1:0]   cur_bank_reg, cur_bank_next;
  logic [NUM_BANKS-1:0] bank_full_reg, bank_full_next;
  logic                 overflow_reg, overflow_next;
  logic [15:0]          frame_cnt_reg, frame_cnt_next;
  logic [15:0]          line_cnt_reg, line_cnt_next;
  logic [1:0]           mode_reg, mode_next;
  logic [31:0]          freerun_reg, freerun_next;
  logic [7:0]           ramp_reg, ramp_next;

  // A completed word is staged here for one cycle before it reaches the
  // RAM port; the bank-full flag for a closing bank rides along with it so
  // software never sees "full" before the last word has been issued.
  logic                 pend_wen_reg, pend_wen_next;
  logic                 pend_full_reg, pend_full_next;
  logic [DW-1:0]        pend_data_reg, pend_data_next;
  logic [BANK_AW-1:0]   pend_addr_reg, pend_addr_next;
  logic [BANK_IW-1:0]   pend_bank_reg, pend_bank_next;

  logic [BANK_AW-1:0]   ram_wa_reg, ram_wa_next;
  logic [DW-1:0]        ram_wd_reg, ram_wd_next;
  logic [NUM_BANKS-1:0] ram_wen_reg, ram_wen_next;

  logic [NUM_BANKS-1:0] rel_pulse;
  logic                 vs_rise, vs_fall, href_fall, bv;
  logic [7:0]           byte_in;
  logic [BANK_IW-1:0]   nxt_bank;
  logic [DW-1:0]        word_full;

  // Release toggles: one synchroniser per bank.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_rel_sync
      cam_tgl_sync u_sync (
        .PCLKI     (PCLKI),
        .WBs_RST_i (WBs_RST_i),
        .tgl       (bank_rel_tgl_i[gi]),
        .pulse     (rel_pulse[gi])
      );
    end
  endgenerate

  assign vs_rise   = VSYNCI & ~vsync_reg;
  assign vs_fall   = ~VSYNCI & vsync_reg;
  assign href_fall = href_reg & ~HREFI;
  assign bv        = VSYNCI & HREFI & (state_reg == CAPTURE);
  assign byte_in   = (mode_reg == MODE_RAMP) ? ramp_reg : CAM_D_i;

  // Explicit wrap so non-power-of-two bank counts cycle correctly.
  assign nxt_bank  = (cur_bank_reg == BANK_IW'(NUM_BANKS - 1)) ? '0
                                                                : cur_bank_reg + BANK_IW'(1);

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    pack_next      = pack_reg;
    addr_next      = addr_reg;
    cur_bank_next  = cur_bank_reg;
    overflow_next  = overflow_reg;
    frame_cnt_next = frame_cnt_reg;
    line_cnt_next  = line_cnt_reg;
    mode_next      = mode_reg;
    freerun_next   = freerun_reg;
    ramp_next      = ramp_reg;
    pend_wen_next  = 1'b0;
    pend_full_next = 1'b0;
    pend_data_next = pend_data_reg;
    pend_addr_next = pend_addr_reg;
    pend_bank_next = pend_bank_reg;
    word_full      = pack_reg;
    word_full[{byte_cnt_reg, 3'b000} +: 8] = byte_in;

    if (enable_i && !enable_reg)
      overflow_next = 1'b0;

    if (href_fall && VSYNCI && (state_reg == CAPTURE || state_reg == STALL) &&
        line_cnt_reg != 16'hFFFF)
      line_cnt_next = line_cnt_reg + 16'd1;

    if (!enable_i) begin
      state_next    = IDLE;
      byte_cnt_next = '0;
      pack_next     = '0;
      addr_next     = '0;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT_FRAME;

        WAIT_FRAME: begin
          if (vs_rise) begin
            line_cnt_next = '0;
            ramp_next     = '0;
            byte_cnt_next = '0;
            pack_next     = '0;
            addr_next     = '0;
            mode_next     = (mode_i == MODE_RSVD) ? MODE_CAM : mode_i;
            if (bank_full_reg[cur_bank_reg]) begin
              state_next    = STALL;
              overflow_next = 1'b1;
            end else begin
              state_next = CAPTURE;
            end
          end
        end

        CAPTURE: begin
          if (vs_fall) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = WAIT_FRAME;
            byte_cnt_next  = '0;
            pack_next      = '0;
            pend_bank_next = cur_bank_reg;
            if (byte_cnt_reg != '0) begin
              // Upper bytes of pack_reg are still zero: natural padding.
              pend_wen_next  = 1'b1;
              pend_addr_next = addr_reg;
              pend_data_next = (mode_reg == MODE_FREERUN) ? freerun_reg[DW-1:0] : pack_reg;
              freerun_next   = freerun_reg + 32'd1;
            end
            // A flush always leaves the bank non-empty, so it always closes it.
            if (byte_cnt_reg != '0 || addr_reg != '0) begin
              pend_full_next = 1'b1;
              cur_bank_next  = nxt_bank;
              addr_next      = '0;
            end
          end else if (bv) begin
            ramp_next = ramp_reg + 8'd1;
            if (byte_cnt_reg == BCW'(BPW - 1)) begin
              pend_wen_next  = 1'b1;
              pend_addr_next = addr_reg;
              pend_bank_next = cur_bank_reg;
              pend_data_next = (mode_reg == MODE_FREERUN) ? freerun_reg[DW-1:0] : word_full;
              freerun_next   = freerun_reg + 32'd1;
              byte_cnt_next  = '0;
              pack_next      = '0;
              if (addr_reg == '1) begin
                pend_full_next = 1'b1;
                cur_bank_next  = nxt_bank;
                addr_next      = '0;
                if (bank_full_reg[nxt_bank]) begin
                  state_next    = STALL;
                  overflow_next = 1'b1;
                end
              end else begin
                addr_next = addr_reg + BANK_AW'(1);
              end
            end else begin
              pack_next     = word_full;
              byte_cnt_next = byte_cnt_reg + BCW'(1);
            end
          end
        end

        STALL: begin
          byte_cnt_next = '0;
          pack_next     = '0;
          if (vs_fall) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = WAIT_FRAME;
          end else if (!bank_full_reg[cur_bank_reg]) begin
            state_next = CAPTURE;
            addr_next  = '0;
          end
        end

        default: state_next = IDLE;
      endcase
    end

    ram_wen_next = pend_wen_reg ? (NUM_BANKS'(1) << pend_bank_reg) : '0;
    ram_wa_next  = pend_wen_reg ? pend_addr_reg : ram_wa_reg;
    ram_wd_next  = pend_wen_reg ? pend_data_reg : ram_wd_reg;

    // Set is applied after release so a coincident set wins.
    bank_full_next = bank_full_reg & ~rel_pulse;
    if (pend_full_reg)
      bank_full_next[pend_bank_reg] = 1'b1;
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      vsync_reg     <= 1'b0;
      href_reg      <= 1'b0;
      enable_reg    <= 1'b0;
      byte_cnt_reg  <= '0;
      pack_reg      <= '0;
      addr_reg      <= '0;
      cur_bank_reg  <= '0;
      bank_full_reg <= '0;
      overflow_reg  <= 1'b0;
      frame_cnt_reg <= '0;
      line_cnt_reg  <= '0;
      mode_reg      <= MODE_CAM;
      freerun_reg   <= '0;
      ramp_reg      <= '0;
      pend_wen_reg  <= 1'b0;
      pend_full_reg <= 1'b0;
      pend_data_reg <= '0;
      pend_addr_reg <= '0;
      pend_bank_reg <= '0;
      ram_wa_reg    <= '0;
      ram_wd_reg    <= '0;
      ram_wen_reg   <= '0;
    end else begin
      vsync_reg     <= VSYNCI;
      href_reg      <= HREFI;
      enable_reg    <= enable_i;
      byte_cnt_reg  <= byte_cnt_next;
      pack_reg      <= pack_next;
      addr_reg      <= addr_next;
      cur_bank_reg  <= cur_bank_next;
      bank_full_reg <= bank_full_next;
      overflow_reg  <= overflow_next;
      frame_cnt_reg <= frame_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      mode_reg      <= mode_next;
      freerun_reg   <= freerun_next;
      ramp_reg      <= ramp_next;
      pend_wen_reg  <= pend_wen_next;
      pend_full_reg <= pend_full_next;
      pend_data_reg <= pend_data_next;
      pend_addr_reg <= pend_addr_next;
      pend_bank_reg <= pend_bank_next;
      ram_wa_reg    <= ram_wa_next;
      ram_wd_reg    <= ram_wd_next;
      ram_wen_reg   <= ram_wen_next;
    end
  end

  assign ram_wa_o    = ram_wa_reg;
  assign ram_wd_o    = ram_wd_reg;
  assign ram_wen_o   = ram_wen_reg;
  assign bank_full_o = bank_full_reg;
  assign cur_bank_o  = cur_bank_reg;
  assign overflow_o  = overflow_reg;
  assign frame_cnt_o = frame_cnt_reg;
  assign line_cnt_o  = line_cnt_reg;

endmodule

// File: tb/tb_cam_bank_packer.sv
// Directed bench for cam_bank_packer with a small geometry
// (4 bytes/word, 2 banks of 4 words) so bank wrap and overflow are quick to reach.
module tb_cam_bank_packer;

  logic        PCLKI;
  logic        WBs_RST_i;
  logic        VSYNCI;
  logic        HREFI;
  logic [7:0]  CAM_D_i;
  logic        enable_i;
  logic [1:0]  mode_i;
  logic [1:0]  bank_rel_tgl_i;
  logic [1:0]  ram_wa_o;
  logic [31:0] ram_wd_o;
  logic [1:0]  ram_wen_o;
  logic [1:0]  bank_full_o;
  logic [0:0]  cur_bank_o;
  logic        overflow_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] line_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [1:0]  log_wen[$];
  logic [1:0]  log_wa[$];
  logic [31:0] log_wd[$];

  cam_bank_packer #(.BPW(4), .NUM_BANKS(2), .BANK_AW(2), .BANK_IW(1)) dut (
    .PCLKI          (PCLKI),
    .WBs_RST_i      (WBs_RST_i),
    .VSYNCI         (VSYNCI),
    .HREFI          (HREFI),
    .CAM_D_i        (CAM_D_i),
    .enable_i       (enable_i),
    .mode_i         (mode_i),
    .bank_rel_tgl_i (bank_rel_tgl_i),
    .ram_wa_o       (ram_wa_o),
    .ram_wd_o       (ram_wd_o),
    .ram_wen_o      (ram_wen_o),
    .bank_full_o    (bank_full_o),
    .cur_bank_o     (cur_bank_o),
    .overflow_o     (overflow_o),
    .frame_cnt_o    (frame_cnt_o),
    .line_cnt_o     (line_cnt_o)
  );

  initial PCLKI = 1'b0;
  always #5 PCLKI = ~PCLKI;

  // Record every RAM write, sampled mid-cycle.
  always @(negedge PCLKI) begin
    if (ram_wen_o != 2'b00) begin
      log_wen.push_back(ram_wen_o);
      log_wa.push_back(ram_wa_o);
      log_wd.push_back(ram_wd_o);
      $display("write wen=%b wa=%0d wd=%h", ram_wen_o, ram_wa_o, ram_wd_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLKI);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    HREFI   = 1'b1;
    CAM_D_i = b;
    tick();
  endtask

  task automatic clear_log();
    log_wen.delete();
    log_wa.delete();
    log_wd.delete();
  endtask

  task automatic do_reset();
    VSYNCI = 1'b0; HREFI = 1'b0; CAM_D_i = 8'h00;
    enable_i = 1'b0; mode_i = 2'd0; bank_rel_tgl_i = 2'b00;
    WBs_RST_i = 1'b1;
    tick(); tick();
    WBs_RST_i = 1'b0;
    tick();
    clear_log();
  endtask

  task automatic test_reset();
    WBs_RST_i = 1'b0; VSYNCI = 1'b0; HREFI = 1'b0; CAM_D_i = 8'h00;
    enable_i = 1'b0; mode_i = 2'd0; bank_rel_tgl_i = 2'b00;
    #1 WBs_RST_i = 1'b1;
    #2;
    checks++; if ({ram_wa_o, ram_wd_o, ram_wen_o, bank_full_o, cur_bank_o, overflow_o, frame_cnt_o, line_cnt_o} !== '0) begin errors++; $display("FAIL reset_outputs got wd=%h wen=%b full=%b ovf=%b fc=%0d lc=%0d exp all zero", ram_wd_o, ram_wen_o, bank_full_o, overflow_o, frame_cnt_o, line_cnt_o); end
    $display("reset: outputs checked");
    do_reset();
  endtask

  task automatic test_pack();
    do_reset();
    enable_i = 1'b1; tick();
    VSYNCI = 1'b1; tick();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (ram_wen_o !== 2'b00) begin errors++; $display("FAIL pack_latency wen got %b exp %b", ram_wen_o, 2'b00); end
    send_byte(8'h55);
    checks++; if (ram_wen_o !== 2'b01) begin errors++; $display("FAIL pack_w0_wen got %b exp %b", ram_wen_o, 2'b01); end
    checks++; if (ram_wd_o !== 32'h44332211) begin errors++; $display("FAIL pack_w0_wd got %h exp %h", ram_wd_o, 32'h44332211); end
    checks++; if (ram_wa_o !== 2'd0) begin errors++; $display("FAIL pack_w0_wa got %0d exp 0", ram_wa_o); end
    send_byte(8'h66);
    checks++; if (ram_wen_o !== 2'b00) begin errors++; $display("FAIL pack_pulse_width wen got %b exp %b", ram_wen_o, 2'b00); end
    send_byte(8'h77); send_byte(8'h88);
    HREFI = 1'b0; tick();
    checks++; if (ram_wen_o !== 2'b01 || ram_wd_o !== 32'h88776655 || ram_wa_o !== 2'd1) begin errors++; $display("FAIL pack_w1 got wen=%b wd=%h wa=%0d exp wen=01 wd=88776655 wa=1", ram_wen_o, ram_wd_o, ram_wa_o); end
    checks++; if (line_cnt_o !== 16'd1) begin errors++; $display("FAIL pack_line_cnt got %0d exp 1", line_cnt_o); end
    VSYNCI = 1'b0; tick(); tick(); tick();
    checks++; if (log_wen.size() !== 2) begin errors++; $display("FAIL pack_write_count got %0d exp 2", log_wen.size()); end
    checks++; if (bank_full_o !== 2'b01 || cur_bank_o !== 1'b1) begin errors++; $display("FAIL pack_close got full=%b cur=%0d exp full=01 cur=1", bank_full_o, cur_bank_o); end
    checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL pack_frame_cnt got %0d exp 1", frame_cnt_o); end
    $display("pack: two words written");
  endtask

  task automatic test_overflow();
    do_reset();
    enable_i = 1'b1; tick();
    VSYNCI = 1'b1; tick();
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    HREFI = 1'b0; tick(); tick(); tick();
    checks++; if (log_wen.size() !== 8) begin errors++; $display("FAIL ovf_write_count got %0d exp 8", log_wen.size()); end
    if (log_wen.size() >= 8) begin
      checks++; if (log_wen[3] !== 2'b01 || log_wa[3] !== 2'd3 || log_wd[3] !== 32'h0F0E0D0C) begin errors++; $display("FAIL ovf_w3 got wen=%b wa=%0d wd=%h exp 01/3/0f0e0d0c", log_wen[3], log_wa[3], log_wd[3]); end
      checks++; if (log_wen[7] !== 2'b10 || log_wa[7] !== 2'd3 || log_wd[7] !== 32'h1F1E1D1C) begin errors++; $display("FAIL ovf_w7 got wen=%b wa=%0d wd=%h exp 10/3/1f1e1d1c", log_wen[7], log_wa[7], log_wd[7]); end
    end
    checks++; if (bank_full_o !== 2'b11) begin errors++; $display("FAIL ovf_full got %b exp 11", bank_full_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_o); end
    checks++; if (cur_bank_o !== 1'b0) begin errors++; $display("FAIL ovf_cur_bank got %0d exp 0", cur_bank_o); end
    checks++; if (line_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_line_in_stall got %0d exp 1", line_cnt_o); end
    $display("overflow: stalled with both banks full");
  endtask

  task automatic test_release();
    clear_log();
    bank_rel_tgl_i[0] = 1'b1;
    tick(); tick();
    checks++; if (bank_full_o !== 2'b11) begin errors++; $display("FAIL rel_sync_delay got %b exp 11", bank_full_o); end
    tick();
    checks++; if (bank_full_o !== 2'b10) begin errors++; $display("FAIL rel_clear got %b exp 10", bank_full_o); end
    tick();
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    HREFI = 1'b0; tick(); tick();
    checks++; if (log_wen.size() !== 1) begin errors++; $display("FAIL rel_resume_count got %0d exp 1", log_wen.size()); end
    if (log_wen.size() >= 1) begin
      checks++; if (log_wen[0] !== 2'b01 || log_wa[0] !== 2'd0 || log_wd[0] !== 32'hA3A2A1A0) begin errors++; $display("FAIL rel_resume_word got wen=%b wa=%0d wd=%h exp 01/0/a3a2a1a0", log_wen[0], log_wa[0], log_wd[0]); end
    end
    // Toggling a bank that is not full must not disturb anything.
    bank_rel_tgl_i[0] = 1'b0;
    repeat (4) tick();
    checks++; if (bank_full_o !== 2'b10) begin errors++; $display("FAIL rel_not_full_ignored got %b exp 10", bank_full_o); end
    enable_i = 1'b0; tick();
    checks++; if (overflow_o !== 1'b1 || bank_full_o !== 2'b10) begin errors++; $display("FAIL idle_keeps_state got ovf=%b full=%b exp 1/10", overflow_o, bank_full_o); end
    enable_i = 1'b1; tick();
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_enable got %b exp 0", overflow_o); end
    $display("release: capture resumed in bank 0");
  endtask

  task automatic test_flush();
    do_reset();
    enable_i = 1'b1; tick();
    VSYNCI = 1'b1; tick();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
    HREFI = 1'b0; tick();
    VSYNCI = 1'b0; tick(); tick(); tick();
    checks++; if (log_wen.size() !== 2) begin errors++; $display("FAIL flush_count got %0d exp 2", log_wen.size()); end
    if (log_wen.size() >= 2) begin
      checks++; if (log_wd[0] !== 32'hDDCCBBAA || log_wa[0] !== 2'd0) begin errors++; $display("FAIL flush_w0 got wd=%h wa=%0d exp ddccbbaa/0", log_wd[0], log_wa[0]); end
      checks++; if (log_wd[1] !== 32'h0000FFEE || log_wa[1] !== 2'd1 || log_wen[1] !== 2'b01) begin errors++; $display("FAIL flush_w1 got wd=%h wa=%0d wen=%b exp 0000ffee/1/01", log_wd[1], log_wa[1], log_wen[1]); end
    end
    checks++; if (bank_full_o !== 2'b01 || cur_bank_o !== 1'b1 || frame_cnt_o !== 16'd1) begin errors++; $display("FAIL flush_close got full=%b cur=%0d fc=%0d exp 01/1/1", bank_full_o, cur_bank_o, frame_cnt_o); end
    $display("flush: partial word padded");
  endtask

  task automatic test_freerun();
    logic [1:0] exp_wen;
    do_reset();
    mode_i = 2'd1; enable_i = 1'b1; tick();
    for (int f = 0; f < 3; f++) begin
      VSYNCI = 1'b1; tick();
      for (int i = 0; i < 8; i++) send_byte(8'h5A);
      HREFI = 1'b0; tick();
      VSYNCI = 1'b0; tick(); tick();
      bank_rel_tgl_i[f % 2] = ~bank_rel_tgl_i[f % 2];
      repeat (5) tick();
    end
    checks++; if (log_wd.size() !== 6) begin errors++; $display("FAIL freerun_count got %0d exp 6", log_wd.size()); end
    for (int i = 0; i < log_wd.size() && i < 6; i++) begin
      exp_wen = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (log_wd[i] !== 32'(i) || log_wa[i] !== 2'(i % 2) || log_wen[i] !== exp_wen) begin errors++; $display("FAIL freerun_w%0d got wd=%h wa=%0d wen=%b exp wd=%h wa=%0d wen=%b", i, log_wd[i], log_wa[i], log_wen[i], 32'(i), i % 2, exp_wen); end
    end
    checks++; if (frame_cnt_o !== 16'd3 || overflow_o !== 1'b0) begin errors++; $display("FAIL freerun_frames got fc=%0d ovf=%b exp 3/0", frame_cnt_o, overflow_o); end
    $display("freerun: counter words across frames");
  endtask

  task automatic test_ramp();
    do_reset();
    mode_i = 2'd2; enable_i = 1'b1; tick();
    VSYNCI = 1'b1; tick();
    for (int i = 0; i < 8; i++) send_byte(8'hEE);
    HREFI = 1'b0; tick();
    VSYNCI = 1'b0; tick(); tick(); tick();
    VSYNCI = 1'b1; tick();
    mode_i = 2'd0;  // must not take effect until the next frame start
    for (int i = 0; i < 4; i++) send_byte(8'hEE);
    HREFI = 1'b0; tick();
    VSYNCI = 1'b0; tick(); tick(); tick();
    checks++; if (log_wd.size() !== 3) begin errors++; $display("FAIL ramp_count got %0d exp 3", log_wd.size()); end
    if (log_wd.size() >= 3) begin
      checks++; if (log_wd[0] !== 32'h03020100 || log_wd[1] !== 32'h07060504) begin errors++; $display("FAIL ramp_frame1 got %h %h exp 03020100 07060504", log_wd[0], log_wd[1]); end
      checks++; if (log_wd[2] !== 32'h03020100 || log_wen[2] !== 2'b10) begin errors++; $display("FAIL ramp_frame2 got wd=%h wen=%b exp 03020100/10", log_wd[2], log_wen[2]); end
    end
    $display("ramp: byte ramp restarted per frame");
  endtask

  task automatic test_enable_drop();
    clear_log();
    bank_rel_tgl_i = ~bank_rel_tgl_i;
    repeat (5) tick();
    checks++; if (bank_full_o !== 2'b00) begin errors++; $display("FAIL drop_release_both got %b exp 00", bank_full_o); end
    VSYNCI = 1'b1; tick();
    send_byte(8'h01); send_byte(8'h02);
    HREFI = 1'b0; enable_i = 1'b0; tick();
    repeat (4) tick();
    checks++; if (log_wd.size() !== 0) begin errors++; $display("FAIL drop_no_write got %0d writes exp 0", log_wd.size()); end
    checks++; if (frame_cnt_o !== 16'd2) begin errors++; $display("FAIL drop_frame_kept got %0d exp 2", frame_cnt_o); end
    enable_i = 1'b1; tick();
    for (int i = 3; i < 7; i++) send_byte(8'(i));
    HREFI = 1'b0; tick(); tick();
    checks++; if (log_wd.size() !== 0) begin errors++; $display("FAIL wait_no_rise got %0d writes exp 0", log_wd.size()); end
    #2 WBs_RST_i = 1'b1;
    #1;
    checks++; if ({ram_wa_o, ram_wd_o, ram_wen_o, bank_full_o, cur_bank_o, overflow_o, frame_cnt_o, line_cnt_o} !== '0) begin errors++; $display("FAIL midframe_reset got wd=%h full=%b fc=%0d lc=%0d exp all zero", ram_wd_o, bank_full_o, frame_cnt_o, line_cnt_o); end
    tick();
    WBs_RST_i = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    HREFI = 1'b0; tick(); tick();
    checks++; if (log_wd.size() !== 0) begin errors++; $display("FAIL post_reset_wait got %0d writes exp 0", log_wd.size()); end
    VSYNCI = 1'b0; tick();
    VSYNCI = 1'b1; tick();
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    HREFI = 1'b0; tick(); tick();
    checks++; if (log_wd.size() !== 1) begin errors++; $display("FAIL post_reset_count got %0d exp 1", log_wd.size()); end
    if (log_wd.size() >= 1) begin
      checks++; if (log_wd[0] !== 32'h24232221 || log_wa[0] !== 2'd0 || log_wen[0] !== 2'b01) begin errors++; $display("FAIL post_reset_word got wd=%h wa=%0d wen=%b exp 24232221/0/01", log_wd[0], log_wa[0], log_wen[0]); end
    end
    $display("enable_drop: partial discarded, reset recovered");
  endtask

  initial begin
    test_reset();
    test_pack();
    test_overflow();
    test_release();
    test_flush();
    test_freerun();
    test_ramp();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
